// File: rtl/axil_reg_bank_if.sv
// AXI-Lite connection between a master and the axil_reg_bank slave.
// A beat moves on the rising edge where valid && ready; valid holds with a stable payload until then.
interface axil_reg_bank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: flat array of byte-strobed R/W registers with per-register write pulses.
// AW and W are captured independently; out-of-range word indices answer SLVERR.
module axil_reg_bank #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  axil_reg_bank_if.slave               bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]          o_wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  aw_full, w_full, bvalid_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, commit, w_in_range;
  logic [ADDR_WIDTH-1:0] cw_addr, w_word;
  logic [DATA_WIDTH-1:0] cw_data;
  logic [STRB_W-1:0]     cw_strb;

  r_state_t              r_state, r_state_next;
  logic                  ar_hs, r_in_range;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_sel, rdata_q;
  logic [1:0]            rresp_q;

  logic unused_prot;
  assign unused_prot = ^{bus.awprot, bus.arprot};

  assign bus.awready = !aw_full && !bvalid_q;
  assign bus.wready  = !w_full && !bvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  // Address and data each come from the holder if parked there, else from the live beat.
  assign commit     = (aw_full || aw_hs) && (w_full || w_hs);
  assign cw_addr    = aw_full ? aw_addr_q : bus.awaddr;
  assign cw_data    = w_full ? w_data_q : bus.wdata;
  assign cw_strb    = w_full ? w_strb_q : bus.wstrb;
  assign w_word     = cw_addr >> OFFS;
  assign w_in_range = w_word < NUM_REGS_A;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= bus.awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && w_in_range && (w_word == ADDR_WIDTH'(k))) begin
          wr_pulse_q[k] <= 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (cw_strb[b]) regs_q[k][b*8 +: 8] <= cw_data[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
  assign o_wr_pulse = wr_pulse_q;

  // Read FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= R_IDLE;
    else          r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (bus.arvalid) r_state_next = R_RESP;
      R_RESP:  if (bus.rready)  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  bus.arready = 1'b1;
      R_RESP:  bus.rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign ar_hs      = bus.arvalid && (r_state == R_IDLE);
  assign r_word     = bus.araddr >> OFFS;
  assign r_in_range = r_word < NUM_REGS_A;

  always_comb begin
    r_sel = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (r_word == ADDR_WIDTH'(k)) r_sel = regs_q[k];
  end

  // Read data is captured from regs_q before any same-edge write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= r_in_range ? r_sel : '0;
      rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: drivers push expected B/R responses, a monitor pops and compares them.
module tb_axil_reg_bank;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int NR = 16;
  localparam int SW = DW / 8;
  localparam int CW = 128;
  localparam logic [DW-1:0] RV = 64'hC0DE0000000000A5;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]    wr_pulse;

  axil_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RESET_VALUE(RV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_regs(regs), .o_wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [1:0]    exp_b_q[$];
  logic [DW+1:0] exp_r_q[$];
  logic [NR*DW-1:0] model;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < NR; k++)
      check($sformatf("%s[%0d]", name, k), regs[k*DW +: DW], model[k*DW +: DW]);
  endtask

  // Monitor: each B/R handshake is seen once, at the negedge before its edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b_q.size() == 0) begin
          n_checks++;
          $display("FAIL bresp_unexpected: got response %b, required none", bus.bresp);
        end else check("bresp", bus.bresp, exp_b_q.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r_q.size() == 0) begin
          n_checks++;
          $display("FAIL rresp_unexpected: got %b/%h, required none", bus.rresp, bus.rdata);
        end else check("rresp_rdata", {bus.rresp, bus.rdata}, exp_r_q.pop_front());
      end
    end
  end

  task automatic write_split(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                             input logic [DW-1:0] new_val, input bit push_b);
    logic aw_done, w_done, aw_hit, w_hit, in_range;
    logic [AW-1:0] idx;
    logic [NR-1:0] exp_pulse;
    idx = addr >> 3;
    in_range = idx < AW'(NR);
    exp_pulse = in_range ? (NR'(1) << idx) : '0;
    if (push_b) exp_b_q.push_back(in_range ? OKAY : SLVERR);
    aw_done = 1'b0;
    w_done = 1'b0;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      if (n == aw_dly) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
      if (n == w_dly) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
      @(negedge clk);
      if (aw_done && !w_done) check("awready_low_while_held", bus.awready, 0);
      if (w_done && !aw_done) check("wready_low_while_held", bus.wready, 0);
      aw_hit = bus.awvalid && bus.awready;
      w_hit = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hit) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_hit) begin w_done = 1'b1; bus.wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      n_checks++;
      $display("FAIL write_handshake_timeout: aw_done=%b w_done=%b, required both 1", aw_done, w_done);
    end
    if (in_range) model[int'(idx)*DW +: DW] = new_val;
    @(negedge clk);
    check("bvalid_after_commit", bus.bvalid, 1);
    check("wr_pulse", wr_pulse, exp_pulse);
    check_regs("regs_after_write");
    @(negedge clk);
    check("wr_pulse_one_cycle", wr_pulse, 0);
    if (bus.bready) check("aw_w_reaccept", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW+1:0] exp);
    logic hit;
    bit done;
    done = 1'b0;
    exp_r_q.push_back(exp);
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      hit = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (hit) begin done = 1'b1; bus.arvalid = 1'b0; end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL read_handshake_timeout: arready never seen, required within 40 cycles");
    end
    @(negedge clk);
    check("rvalid_latency", bus.rvalid, 1);
    @(negedge clk);
    if (bus.rready) check("arready_reaccept", bus.arready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.bvalid || bus.rvalid) && n < 50);
    if (bus.bvalid || bus.rvalid) begin
      n_checks++;
      $display("FAIL idle_timeout: bvalid=%b rvalid=%b, required 0", bus.bvalid, bus.rvalid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    model = {NR{RV}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("reset_b", {bus.bvalid, bus.bresp}, 3'b000);
    check("reset_r", {bus.rvalid, bus.rresp, bus.rdata}, 0);
    check("reset_pulse", wr_pulse, 0);
    check_regs("reset_regs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_read(16'h0008, {OKAY, RV});
    wait_idle();

    write_split(16'h0010, 64'h1122334455667788, 8'hFF, 0, 0, 64'h1122334455667788, 1'b1);
    wait_idle();
    do_read(16'h0010, {OKAY, 64'h1122334455667788});
    wait_idle();
    do_read(16'h0013, {OKAY, 64'h1122334455667788});
    wait_idle();

    // W three cycles ahead of AW, low lanes only
    write_split(16'h0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, 3, 0, 64'h11223344BBBBBBBB, 1'b1);
    wait_idle();
    // AW three cycles ahead of W, high lanes only
    write_split(16'h0008, 64'hCAFEF00D12345678, 8'hF0, 0, 3, 64'hCAFEF00D000000A5, 1'b1);
    wait_idle();
    write_split(16'h0018, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0, RV, 1'b1);
    wait_idle();
    write_split(16'h007F, 64'h0102030405060708, 8'hFF, 1, 1, 64'h0102030405060708, 1'b1);
    wait_idle();

    write_split(16'h0080, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 0, 64'h0, 1'b1);
    wait_idle();
    do_read(16'h0080, {SLVERR, 64'h0});
    wait_idle();
    do_read(16'hFFF8, {SLVERR, 64'h0});
    wait_idle();

    // Back-pressure on B: a second write is offered but must not be taken
    bus.bready = 1'b0;
    write_split(16'h0020, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 64'h0123456789ABCDEF, 1'b1);
    bus.awaddr = 16'h0028; bus.awvalid = 1'b1;
    bus.wdata = 64'h5555555555555555; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, OKAY, 2'b00});
      check("b_hold_no_pulse", wr_pulse, 0);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    wait_idle();
    check_regs("regs_after_b_hold");

    // Back-pressure on R
    bus.rready = 1'b0;
    do_read(16'h0020, {OKAY, 64'h0123456789ABCDEF});
    bus.araddr = 16'h0010; bus.arvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("r_hold", {bus.rvalid, bus.rresp, bus.rdata, bus.arready},
            {1'b1, OKAY, 64'h0123456789ABCDEF, 1'b0});
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    wait_idle();

    // Read and write commit to reg 2 on the same edge: read sees the old value
    exp_r_q.push_back({OKAY, 64'h11223344BBBBBBBB});
    exp_b_q.push_back(OKAY);
    bus.awaddr = 16'h0010; bus.awvalid = 1'b1;
    bus.wdata = 64'h9999888877776666; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    bus.araddr = 16'h0010; bus.arvalid = 1'b1;
    @(negedge clk);
    check("same_edge_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    model[2*DW +: DW] = 64'h9999888877776666;
    @(negedge clk);
    check("same_edge_pulse", wr_pulse, 16'h0004);
    check("same_edge_valids", {bus.bvalid, bus.rvalid}, 2'b11);
    check_regs("regs_same_edge");
    @(posedge clk); #1;
    wait_idle();

    // Reset while a response is pending: dropped, outputs back to reset at once
    bus.bready = 1'b0;
    write_split(16'h0030, 64'h7777777777777777, 8'hFF, 0, 0, 64'h7777777777777777, 1'b0);
    rst_n = 1'b0;
    #2;
    check("async_reset_ctrl", {bus.bvalid, bus.awready, bus.wready, bus.arready, bus.rvalid}, 5'b01110);
    check("async_reset_pulse", wr_pulse, 0);
    model = {NR{RV}};
    check_regs("regs_async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    write_split(16'h0038, 64'h0A0B0C0D0E0F1011, 8'hFF, 0, 0, 64'h0A0B0C0D0E0F1011, 1'b1);
    wait_idle();
    do_read(16'h0038, {OKAY, 64'h0A0B0C0D0E0F1011});
    wait_idle();

    check("exp_b_q_drained", exp_b_q.size(), 0);
    check("exp_r_q_drained", exp_r_q.size(), 0);
    check_regs("regs_final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
